// File: rtl/regfile_pkg.sv
// Shared constants and elaboration-time helpers for the parameterised register file.
package regfile_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_DEPTH = 4;

  // Ceiling log2, used to size address buses from the register count.
  function automatic int clog2(input int value);
    int result;
    int remain;
    result = 0;
    remain = value - 1;
    while (remain > 0) begin
      result = result + 1;
      remain = remain >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port: storage select, write bypass, zero-register
// override and reservation-based valid flag.
module rf_read_port
  import regfile_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int AW       = clog2(DEFAULT_DEPTH),
  parameter int ZERO_REG = 1
) (
  input  logic [DEPTH*WIDTH-1:0] i_regs_flat,
  input  logic [DEPTH-1:0]       i_pend,
  input  logic [AW-1:0]          i_rr,
  input  logic [AW-1:0]          i_wr,
  input  logic [WIDTH-1:0]       i_wd,
  input  logic                   i_wr_en,
  input  logic                   i_rsv_en,
  input  logic [AW-1:0]          i_rsv_addr,
  output logic [WIDTH-1:0]       o_rd,
  output logic                   o_rd_valid
);

  localparam logic [AW-1:0] ZERO_ADDR = {AW{1'b0}};
  localparam bit            ZR        = (ZERO_REG != 0);

  logic [WIDTH-1:0] w_words [DEPTH];

  genvar g;
  generate
    for (g = 0; g < DEPTH; g++) begin : g_unpack
      assign w_words[g] = i_regs_flat[g*WIDTH +: WIDTH];
    end
  endgenerate

  // Select read data and validity; the zero register beats bypass, bypass beats storage.
  // i_wr_en / i_rsv_en arrive already gated against the zero register.
  always_comb begin
    o_rd       = w_words[i_rr];
    o_rd_valid = ~i_pend[i_rr];
    if (ZR && (i_rr == ZERO_ADDR)) begin
      o_rd       = {WIDTH{1'b0}};
      o_rd_valid = 1'b1;
    end else if (i_wr_en && (i_wr == i_rr)) begin
      // A reservation landing on the same edge keeps the register pending.
      o_rd       = i_wd;
      o_rd_valid = ~(i_rsv_en && (i_rsv_addr == i_rr));
    end else begin
      o_rd       = w_words[i_rr];
      o_rd_valid = ~i_pend[i_rr];
    end
  end

endmodule

// File: rtl/param_reg_file.sv
// Two-read/one-write register file with per-register pending (reservation)
// bits, same-cycle write bypass and an optional hardwired zero register.
module param_reg_file
  import regfile_pkg::*;
#(
  parameter int    WIDTH    = DEFAULT_WIDTH,
  parameter int    DEPTH    = DEFAULT_DEPTH,
  parameter int    ZERO_REG = 1,
  localparam int   AW       = clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [AW-1:0]    rr1,
  input  logic [AW-1:0]    rr2,
  output logic [WIDTH-1:0] rd1,
  output logic [WIDTH-1:0] rd2,
  output logic             rd1_valid,
  output logic             rd2_valid,
  input  logic [AW-1:0]    wr,
  input  logic [WIDTH-1:0] wd,
  input  logic             regwrite,
  input  logic             rsv_en,
  input  logic [AW-1:0]    rsv_addr,
  output logic             any_pending
);

  localparam logic [AW-1:0] ZERO_ADDR = {AW{1'b0}};
  localparam bit            ZR        = (ZERO_REG != 0);

  logic [WIDTH-1:0]       r_regs [DEPTH];
  logic [DEPTH-1:0]       r_pend;
  logic [DEPTH-1:0]       w_pend_next;
  logic                   w_wr_en;
  logic                   w_rsv_en;
  logic [DEPTH*WIDTH-1:0] w_regs_flat;

  genvar g;
  generate
    for (g = 0; g < DEPTH; g++) begin : g_flat
      assign w_regs_flat[g*WIDTH +: WIDTH] = r_regs[g];
    end
  endgenerate

  // Suppress writes and reservations aimed at the hardwired zero register.
  always_comb begin
    w_wr_en  = regwrite;
    w_rsv_en = rsv_en;
    if (ZR && (wr == ZERO_ADDR)) begin
      w_wr_en = 1'b0;
    end else begin
      w_wr_en = regwrite;
    end
    if (ZR && (rsv_addr == ZERO_ADDR)) begin
      w_rsv_en = 1'b0;
    end else begin
      w_rsv_en = rsv_en;
    end
  end

  // Next pending vector: a write clears its target, then a reservation sets
  // its target, so a same-edge reserve of the written register stays pending.
  always_comb begin
    w_pend_next = r_pend;
    if (w_wr_en) begin
      w_pend_next[wr] = 1'b0;
    end else begin
      w_pend_next[wr] = r_pend[wr];
    end
    if (w_rsv_en) begin
      w_pend_next[rsv_addr] = 1'b1;
    end else begin
      w_pend_next[rsv_addr] = w_pend_next[rsv_addr];
    end
  end

  // Storage and pending state; reset wins over any concurrent write or reserve.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= {WIDTH{1'b0}};
      end
      r_pend <= {DEPTH{1'b0}};
    end else begin
      if (w_wr_en) begin
        r_regs[wr] <= wd;
      end
      r_pend <= w_pend_next;
    end
  end

  assign any_pending = |r_pend;

  rf_read_port #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .AW       (AW),
    .ZERO_REG (ZERO_REG)
  ) u_port1 (
    .i_regs_flat (w_regs_flat),
    .i_pend      (r_pend),
    .i_rr        (rr1),
    .i_wr        (wr),
    .i_wd        (wd),
    .i_wr_en     (w_wr_en),
    .i_rsv_en    (w_rsv_en),
    .i_rsv_addr  (rsv_addr),
    .o_rd        (rd1),
    .o_rd_valid  (rd1_valid)
  );

  rf_read_port #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .AW       (AW),
    .ZERO_REG (ZERO_REG)
  ) u_port2 (
    .i_regs_flat (w_regs_flat),
    .i_pend      (r_pend),
    .i_rr        (rr2),
    .i_wr        (wr),
    .i_wd        (wd),
    .i_wr_en     (w_wr_en),
    .i_rsv_en    (w_rsv_en),
    .i_rsv_addr  (rsv_addr),
    .o_rd        (rd2),
    .o_rd_valid  (rd2_valid)
  );

endmodule

// File: tb/tb_param_reg_file.sv
// Directed bench for param_reg_file: a vector table for the default build
// plus short sequences for the ZERO_REG=0 and 32x32 builds.
module tb_param_reg_file;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int n_vec = 0;
  int n_bad = 0;

  // Default build: WIDTH=16, DEPTH=4, ZERO_REG=1
  logic        reset, regwrite, rsv_en, rd1_valid, rd2_valid, any_pending;
  logic [1:0]  rr1, rr2, wr, rsv_addr;
  logic [15:0] wd, rd1, rd2;

  param_reg_file #(.WIDTH(16), .DEPTH(4), .ZERO_REG(1)) u_dut (
    .clock(clock), .reset(reset), .rr1(rr1), .rr2(rr2), .rd1(rd1), .rd2(rd2),
    .rd1_valid(rd1_valid), .rd2_valid(rd2_valid), .wr(wr), .wd(wd),
    .regwrite(regwrite), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .any_pending(any_pending)
  );

  // ZERO_REG=0 build
  logic        z_reset, z_regwrite, z_rsv_en, z_rd1_valid, z_rd2_valid, z_any;
  logic [1:0]  z_rr1, z_rr2, z_wr, z_rsv_addr;
  logic [15:0] z_wd, z_rd1, z_rd2;

  param_reg_file #(.WIDTH(16), .DEPTH(4), .ZERO_REG(0)) u_dut_z0 (
    .clock(clock), .reset(z_reset), .rr1(z_rr1), .rr2(z_rr2), .rd1(z_rd1), .rd2(z_rd2),
    .rd1_valid(z_rd1_valid), .rd2_valid(z_rd2_valid), .wr(z_wr), .wd(z_wd),
    .regwrite(z_regwrite), .rsv_en(z_rsv_en), .rsv_addr(z_rsv_addr),
    .any_pending(z_any)
  );

  // WIDTH=32, DEPTH=32 build
  logic        b_reset, b_regwrite, b_rsv_en, b_rd1_valid, b_rd2_valid, b_any;
  logic [4:0]  b_rr1, b_rr2, b_wr, b_rsv_addr;
  logic [31:0] b_wd, b_rd1, b_rd2;

  param_reg_file #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1)) u_dut_big (
    .clock(clock), .reset(b_reset), .rr1(b_rr1), .rr2(b_rr2), .rd1(b_rd1), .rd2(b_rd2),
    .rd1_valid(b_rd1_valid), .rd2_valid(b_rd2_valid), .wr(b_wr), .wd(b_wd),
    .regwrite(b_regwrite), .rsv_en(b_rsv_en), .rsv_addr(b_rsv_addr),
    .any_pending(b_any)
  );

  typedef struct packed {
    logic        rst;
    logic        chk;
    logic [1:0]  rr1;
    logic [1:0]  rr2;
    logic [1:0]  wr;
    logic [15:0] wd;
    logic        we;
    logic        rsv;
    logic [1:0]  ra;
    logic [15:0] e_rd1;
    logic [15:0] e_rd2;
    logic        e_v1;
    logic        e_v2;
    logic        e_any;
  } vec_t;

  vec_t tbl [$];

  function automatic vec_t mk(input logic rst, input logic chk,
                              input logic [1:0] r1, input logic [1:0] r2,
                              input logic [1:0] w, input logic [15:0] d, input logic we,
                              input logic rsv, input logic [1:0] ra,
                              input logic [15:0] e1, input logic [15:0] e2,
                              input logic ev1, input logic ev2, input logic eany);
    vec_t v;
    v = '{rst, chk, r1, r2, w, d, we, rsv, ra, e1, e2, ev1, ev2, eany};
    return v;
  endfunction

  task automatic check(input string name, input int idx,
                       input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    vec_t v;
    logic [31:0] ea, eb;

    reset = 1'b0; regwrite = 1'b0; rsv_en = 1'b0;
    rr1 = 2'd0; rr2 = 2'd0; wr = 2'd0; rsv_addr = 2'd0; wd = 16'h0;
    z_reset = 1'b1; z_regwrite = 1'b0; z_rsv_en = 1'b0;
    z_rr1 = 2'd0; z_rr2 = 2'd0; z_wr = 2'd0; z_rsv_addr = 2'd0; z_wd = 16'h0;
    b_reset = 1'b1; b_regwrite = 1'b0; b_rsv_en = 1'b0;
    b_rr1 = 5'd0; b_rr2 = 5'd0; b_wr = 5'd0; b_rsv_addr = 5'd0; b_wd = 32'h0;

    //            rst chk rr1 rr2 wr  wd         we  rsv ra    rd1        rd2        v1  v2  any
    tbl.push_back(mk(1, 0, 0, 0, 0, 16'h0000, 0, 0, 0,  16'h0000, 16'h0000, 1, 1, 0));
    tbl.push_back(mk(0, 1, 0, 1, 0, 16'h0000, 0, 0, 0,  16'h0000, 16'h0000, 1, 1, 0));
    tbl.push_back(mk(0, 1, 2, 3, 0, 16'h0000, 0, 0, 0,  16'h0000, 16'h0000, 1, 1, 0));
    tbl.push_back(mk(0, 1, 1, 0, 1, 16'hBEEF, 1, 0, 0,  16'hBEEF, 16'h0000, 1, 1, 0));
    tbl.push_back(mk(0, 1, 1, 1, 0, 16'h0000, 0, 0, 0,  16'hBEEF, 16'hBEEF, 1, 1, 0));
    tbl.push_back(mk(0, 1, 0, 1, 0, 16'h1234, 1, 0, 0,  16'h0000, 16'hBEEF, 1, 1, 0));
    tbl.push_back(mk(0, 1, 0, 1, 0, 16'h0000, 0, 0, 0,  16'h0000, 16'hBEEF, 1, 1, 0));
    tbl.push_back(mk(0, 1, 2, 2, 0, 16'h0000, 0, 1, 2,  16'h0000, 16'h0000, 1, 1, 0));
    tbl.push_back(mk(0, 1, 1, 2, 0, 16'h0000, 0, 0, 0,  16'hBEEF, 16'h0000, 1, 0, 1));
    tbl.push_back(mk(0, 1, 2, 2, 2, 16'h00AA, 1, 0, 0,  16'h00AA, 16'h00AA, 1, 1, 1));
    tbl.push_back(mk(0, 1, 2, 2, 0, 16'h0000, 0, 0, 0,  16'h00AA, 16'h00AA, 1, 1, 0));
    tbl.push_back(mk(0, 1, 3, 3, 3, 16'h5555, 1, 1, 3,  16'h5555, 16'h5555, 0, 0, 0));
    tbl.push_back(mk(0, 1, 3, 3, 0, 16'h0000, 0, 0, 0,  16'h5555, 16'h5555, 0, 0, 1));
    tbl.push_back(mk(0, 1, 1, 2, 1, 16'hAAAA, 1, 1, 2,  16'hAAAA, 16'h00AA, 1, 1, 1));
    tbl.push_back(mk(0, 1, 1, 2, 0, 16'h0000, 0, 0, 0,  16'hAAAA, 16'h00AA, 1, 0, 1));
    tbl.push_back(mk(0, 1, 0, 0, 0, 16'h0000, 0, 1, 0,  16'h0000, 16'h0000, 1, 1, 1));
    tbl.push_back(mk(0, 1, 0, 3, 0, 16'h0000, 0, 0, 0,  16'h0000, 16'h5555, 1, 0, 1));
    tbl.push_back(mk(0, 1, 1, 3, 1, 16'hFFFF, 0, 0, 0,  16'hAAAA, 16'h5555, 1, 0, 1));
    tbl.push_back(mk(0, 1, 1, 3, 0, 16'h0000, 0, 0, 0,  16'hAAAA, 16'h5555, 1, 0, 1));
    tbl.push_back(mk(1, 1, 2, 3, 1, 16'h7777, 1, 1, 1,  16'h00AA, 16'h5555, 0, 0, 1));
    tbl.push_back(mk(0, 1, 1, 2, 0, 16'h0000, 0, 0, 0,  16'h0000, 16'h0000, 1, 1, 0));
    tbl.push_back(mk(0, 1, 3, 0, 0, 16'h0000, 0, 0, 0,  16'h0000, 16'h0000, 1, 1, 0));

    tick();

    // Table: each row is one cycle; outputs are checked before the edge that commits it.
    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      reset = v.rst; rr1 = v.rr1; rr2 = v.rr2; wr = v.wr; wd = v.wd;
      regwrite = v.we; rsv_en = v.rsv; rsv_addr = v.ra;
      @(negedge clock);
      if (v.chk) begin
        check("table", i,
              64'({rd1, rd2, rd1_valid, rd2_valid, any_pending}),
              64'({v.e_rd1, v.e_rd2, v.e_v1, v.e_v2, v.e_any}));
      end
      tick();
    end
    reset = 1'b1; regwrite = 1'b0; rsv_en = 1'b0;

    // ZERO_REG=0: register 0 is ordinary (bypass, storage, reservation).
    tick();
    z_reset = 1'b0; z_wr = 2'd0; z_wd = 16'h1234; z_regwrite = 1'b1; z_rr1 = 2'd0; z_rr2 = 2'd1;
    @(negedge clock);
    check("z0_bypass", 0, 64'({z_rd1, z_rd1_valid, z_rd2, z_rd2_valid}),
          64'({16'h1234, 1'b1, 16'h0000, 1'b1}));
    tick();
    z_regwrite = 1'b0; z_wd = 16'hFFFF; z_rsv_en = 1'b1; z_rsv_addr = 2'd0;
    @(negedge clock);
    check("z0_store", 0, 64'({z_rd1, z_rd1_valid, z_any}), 64'({16'h1234, 1'b1, 1'b0}));
    tick();
    z_rsv_en = 1'b0;
    @(negedge clock);
    check("z0_reserve", 0, 64'({z_rd1, z_rd1_valid, z_any}), 64'({16'h1234, 1'b0, 1'b1}));
    tick();
    z_reset = 1'b1;

    // 32x32: walk address-as-data writes, then read back with regwrite=0 noise.
    tick();
    b_reset = 1'b0;
    for (int a = 0; a < 32; a++) begin
      b_wr = 5'(a); b_wd = 32'(a); b_regwrite = 1'b1;
      tick();
    end
    b_regwrite = 1'b0;
    for (int pass = 0; pass < 2; pass++) begin
      for (int a = 0; a < 32; a++) begin
        b_rr1 = 5'(a); b_rr2 = 5'(31 - a);
        b_wr = 5'($urandom_range(0, 31)); b_wd = $urandom;
        ea = 32'(a); eb = 32'(31 - a);
        @(negedge clock);
        check("big_data", pass * 32 + a, {b_rd1, b_rd2}, {ea, eb});
        check("big_flags", pass * 32 + a, 64'({b_rd1_valid, b_rd2_valid, b_any}),
              64'({1'b1, 1'b1, 1'b0}));
        tick();
      end
    end
    b_reset = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/param_reg_file.md
PARAM_REG_FILE -- requirements
Module: param_reg_file

Interface
REQ-001 SHALL have parameter WIDTH, default 16: data width in bits, range 1..64.
REQ-002 SHALL have parameter DEPTH, default 4: number of registers, a power of two, range 2..32.
REQ-003 SHALL have parameter ZERO_REG, default 1: when 1, register 0 is hardwired to zero.
REQ-004 SHALL derive AW = clog2(DEPTH), the address width; AW is not overridable.
REQ-005 clock  in  1  sole clock; all state updates occur on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 rr1, rr2  in  AW  read addresses for port 1 and port 2.
REQ-008 rd1, rd2  out  WIDTH  read data for port 1 and port 2.
REQ-009 rd1_valid, rd2_valid  out  1  addressed register holds no outstanding reservation.
REQ-010 wr  in  AW  write address.
REQ-011 wd  in  WIDTH  write data.
REQ-012 regwrite  in  1  write enable.
REQ-013 rsv_en  in  1  reserve request: marks register rsv_addr as pending (awaiting a producer).
REQ-014 rsv_addr  in  AW  register to reserve.
REQ-015 any_pending  out  1  OR of all pending bits.

Function
REQ-016 Write: rising edge with regwrite=1 and reset=0 loads wd into reg[wr] and clears pend[wr].
REQ-017 Read paths are combinational: rdN = reg[rrN] and rdN_valid = !pend[rrN].
REQ-018 Bypass: when regwrite=1 and wr==rrN (and not the zero register), rdN = wd and rdN_valid = 1 in the same cycle.
REQ-019 Reserve: rising edge with rsv_en=1 sets pend[rsv_addr] in the next cycle.
REQ-020 When reserve and write target the same register on one edge: data is written and pend stays set (the new producer wins); bypass still forwards wd, but rdN_valid = 0.
REQ-021 When reserve and write target different registers on one edge, both take effect.
REQ-022 ZERO_REG=1: address 0 reads 0 with valid=1, and writes and reserves to address 0 are ignored.
REQ-023 ZERO_REG=0: register 0 behaves as an ordinary register.
REQ-024 Both read ports are independent and may address the same register.
REQ-025 Write latency: 1 edge (visible from the following cycle; 0 cycles via bypass).
REQ-026 Unused wd bits SHALL NOT exist: all widths are exactly WIDTH, with no truncation or extension.
REQ-027 regwrite=0 SHALL leave reg and pend unchanged irrespective of wr and wd.

Reset
REQ-028 reset=1 at a rising edge clears every register to 0 and every pend bit to 0; it overrides concurrent write and reserve.
REQ-029 After reset: rd1 = rd2 = 0, rd1_valid = rd2_valid = 1, any_pending = 0.
REQ-030 Reset asserted mid-operation discards all pending reservations; no write in that cycle takes effect.

Structure
REQ-031 Shared package regfile_pkg SHALL hold the default WIDTH/DEPTH constants and the clog2 helper function.
REQ-032 A single sub-module, rf_read_port (address decode, bypass, zero-register and valid logic), SHALL be instantiated twice.
REQ-033 Storage SHALL be a flat register array plus a DEPTH-bit pend vector, with no latches.

Verification
REQ-034 Reset then read all addresses -> every rd = 0, every valid = 1, any_pending = 0.
REQ-035 WIDTH=16, DEPTH=4: write 0xBEEF to r1 with rr1=1 in the same cycle -> rd1 = 0xBEEF via bypass; next cycle rd1 = 0xBEEF from storage.
REQ-036 Write 0x1234 to r0 with ZERO_REG=1 -> rd1 = 0 (rr1=0); repeat with ZERO_REG=0 -> rd1 = 0x1234.
REQ-037 Reserve r2 -> rd2_valid = 0 and any_pending = 1; write 0x00AA to r2 -> rd2 = 0x00AA, rd2_valid = 1, any_pending = 0.
REQ-038 Same edge: reserve r3 and write 0x5555 to r3 -> reg[3] = 0x5555, rd_valid for r3 = 0; assert reset with pend set -> all valid = 1 and all data = 0.
REQ-039 DEPTH=32, WIDTH=32 build: walk writes of address-as-data to every register, read back on both ports -> all match; regwrite=0 cycles leave contents unchanged.
